multicycle_control: RTL

- Parametrised multi-cycle successor to the single-cycle RV32I `control` decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Handshakes with instruction and data memories through req/ready pairs, with a bounded data-memory wait.
- Emits the existing datapath control set plus sequencing strobes (PCWrite, IRWrite) and fault flags, so the datapath can share one ALU and one memory port across cycles.

---
 rtl/klp32_pkg.sv | 32 +++
 rtl/multicycle_control_if.sv | 8 +
 rtl/alu_decode.sv | 15 +
 rtl/multicycle_control.sv | 114 +++++++++++
 4 files changed

// File: rtl/klp32_pkg.sv
// klp32_pkg: shared RV32I opcodes, control encodings and multicycle FSM states
package klp32_pkg;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;
  localparam logic [1:0] WB_PC4 = 2'b11;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;
  localparam logic [31:0] IR_NOP = 32'h0000_0013;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FETCH = 3'd1,
    DECODE = 3'd2,
    EXEC = 3'd3,
    MEM = 3'd4,
    WB = 3'd5,
    TRAP = 3'd6
  } state_t;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction and data memory handshake of the multicycle controller
interface multicycle_control_if #(parameter int n = 32);
  logic [n-1:0] instr;
  logic imem_req, imem_ready, dmem_req, dmem_ready, MemRw;
  logic [2:0] ldU;
  modport master(output imem_req, dmem_req, MemRw, ldU, input instr, imem_ready, dmem_ready);
  modport slave(input imem_req, dmem_req, MemRw, ldU, output instr, imem_ready, dmem_ready);
endinterface

// File: rtl/alu_decode.sv
// alu_decode: maps opcode/funct3/funct7[5] to the ALU operation select
module alu_decode
  import klp32_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_sel
);
  // Only R-type uses funct7[5] freely; I-type honours it for the shift-right pair alone
  always_comb
    alu_sel = opcode == OP_R ? {funct7b5, funct3} :
              opcode == OP_I ? {funct3 == 3'b101 && funct7b5, funct3} :
              opcode == OP_LUI ? ALU_PASSB : ALU_ADD;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: RV32I FETCH/DECODE/EXEC/MEM/WB sequencer driving a shared-ALU datapath
module multicycle_control
  import klp32_pkg::*;
#(
  parameter int n = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter bit TRAP_STICKY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_if.master        bus,
  input  logic                        BrEq,
  input  logic                        BrLT,
  output logic                        IRWrite,
  output logic                        PCWrite,
  output logic                        RegWEn,
  output logic [2:0]                  ImmSel,
  output logic                        ALUsrc1,
  output logic                        ALUsrc2,
  output logic [3:0]                  AluSEL,
  output logic                        BrUn,
  output logic [1:0]                  WBSel,
  output logic                        PCSel,
  output logic                        illegal,
  output logic                        bus_err,
  output logic [2:0]                  state
);
  state_t st;
  logic [n-1:0] ir;
  logic [7:0] cnt;
  logic [6:0] op;
  logic [2:0] f3;
  logic [3:0] alu_sel;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, legal, taken, mem_to;
  logic unused_ir;
  assign op = ir[6:0];
  assign f3 = ir[14:12];
  assign unused_ir = ^{ir[n-1:31], ir[29:15], ir[11:7]};
  assign is_r = op == OP_R;
  assign is_i = op == OP_I;
  assign is_ld = op == OP_LOAD;
  assign is_st = op == OP_STORE;
  assign is_br = op == OP_BR;
  assign is_jal = op == OP_JAL;
  assign is_jalr = op == OP_JALR;
  assign is_lui = op == OP_LUI;
  assign legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui;
  assign taken = f3[2] ? BrLT ^ f3[0] : BrEq ^ f3[0];
  assign mem_to = !bus.dmem_ready && cnt == 8'(MEM_TIMEOUT - 1);
  assign state = st;
  alu_decode u_alu (
    .opcode(op),
    .funct3(f3),
    .funct7b5(ir[30]),
    .alu_sel(alu_sel)
  );
  // Sequence each instruction; IR, wait counter and fault flags live here
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      ir <= n'(IR_NOP);
      cnt <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else
      case (st)
        IDLE: st <= FETCH;
        FETCH: if (bus.imem_ready) begin
          ir <= bus.instr;
          st <= DECODE;
        end
        DECODE: begin
          st <= !legal ? TRAP : is_lui ? WB : EXEC;
          illegal <= !legal;
        end
        EXEC: begin
          st <= is_br ? FETCH : (is_ld || is_st) ? MEM : WB;
          cnt <= '0;
        end
        MEM: if (bus.dmem_ready) st <= is_st ? FETCH : WB;
        else begin
          cnt <= cnt + 8'd1;
          if (mem_to) begin
            st <= TRAP;
            bus_err <= 1'b1;
          end
        end
        WB: st <= FETCH;
        TRAP: if (!TRAP_STICKY) begin
          st <= FETCH;
          illegal <= 1'b0;
          bus_err <= 1'b0;
        end
        default: st <= IDLE;
      endcase
  // Moore controls from state and IR; only the branch outcome in EXEC and the memory handshakes look at inputs
  always_comb begin
    bus.imem_req = st == FETCH;
    IRWrite = st == FETCH && bus.imem_ready;
    ImmSel = !(st inside {DECODE, EXEC, MEM, WB}) ? IMM_I :
             is_st ? IMM_S : is_br ? IMM_B : is_lui ? IMM_U : is_jal ? IMM_J : IMM_I;
    ALUsrc1 = st == EXEC && (is_br || is_jal);
    ALUsrc2 = st == EXEC && !is_r;
    AluSEL = (st == EXEC || st == WB) ? alu_sel : ALU_ADD;
    BrUn = st == EXEC && is_br && f3[1];
    bus.dmem_req = st == MEM;
    bus.MemRw = st == MEM && is_st;
    bus.ldU = st == MEM ? f3 : 3'b000;
    RegWEn = st == WB;
    WBSel = st != WB ? WB_MEM : is_ld ? WB_MEM : is_lui ? WB_IMM : (is_jal || is_jalr) ? WB_PC4 : WB_ALU;
    PCSel = (st == EXEC && is_br && taken) || (st == WB && (is_jal || is_jalr));
    PCWrite = (st == EXEC && is_br) || (st == MEM && is_st && bus.dmem_ready) || st == WB;
  end
endmodule
